// File: rtl/cp0_ctrl_v2_if.sv
// Pipeline-to-CP0 bus: M-stage exception/mtc0/eret inputs, interrupt lines,
// and the read/redirect results returned to the core.
interface cp0_ctrl_v2_if #(
   parameter int NUM_HWINT = 6
);
   logic [NUM_HWINT-1:0] hw_int;
   logic                 exc_req;
   logic [4:0]           exc_code;
   logic                 exc_bd;
   logic [31:0]          exc_pc;
   logic [31:0]          exc_badvaddr;
   logic                 cp0_we;
   logic [4:0]           cp0_addr;
   logic [31:0]          cp0_wdata;
   logic                 eret;
   logic [31:0]          cp0_rdata;
   logic                 exc_take;
   logic [31:0]          handler_pc;
   logic [31:0]          epc_out;
   logic                 exl_out;

   modport master (
      output hw_int, exc_req, exc_code, exc_bd, exc_pc, exc_badvaddr,
             cp0_we, cp0_addr, cp0_wdata, eret,
      input  cp0_rdata, exc_take, handler_pc, epc_out, exl_out
   );

   modport slave (
      input  hw_int, exc_req, exc_code, exc_bd, exc_pc, exc_badvaddr,
             cp0_we, cp0_addr, cp0_wdata, eret,
      output cp0_rdata, exc_take, handler_pc, epc_out, exl_out
   );
endinterface

// File: rtl/cp0_ctrl_v2.sv
// Coprocessor 0: M-stage exception/interrupt arbitration, SR/Cause/EPC/
// BadVAddr/PrID registers and an optional Count/Compare timer.
module cp0_ctrl_v2 #(
   parameter int          NUM_HWINT  = 6,
   parameter bit          TIMER_EN   = 1'b1,
   parameter logic [31:0] PRID_VALUE = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input logic           Clk,
   input logic           Reset,
   cp0_ctrl_v2_if.slave  bus
);

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        timer_pend_q, timer_pend_d;

   logic [5:0]  hw_ext_s;
   logic [5:0]  ip_next_s;
   logic        int_req_s;
   logic        exc_ok_s;
   logic        exc_take_s;
   logic        bad_addr_s;

   assign hw_ext_s   = 6'(bus.hw_int);
   // IP7 shares the top external line with the timer pending flag
   assign ip_next_s  = {hw_ext_s[5] | (TIMER_EN & timer_pend_q), hw_ext_s[4:0]};
   assign int_req_s  = ie_q & ~exl_q & (|(ip_next_s & im_q));
   assign exc_ok_s   = bus.exc_req & ~exl_q;
   assign exc_take_s = ~Reset & (int_req_s | exc_ok_s);
   assign bad_addr_s = (bus.exc_code == 5'd4) || (bus.exc_code == 5'd5);

   // Next-state: exception entry beats eret, which beats mtc0
   always_comb begin
      im_d         = im_q;
      exl_d        = exl_q;
      ie_d         = ie_q;
      bd_d         = bd_q;
      ip_d         = ip_next_s;
      exccode_d    = exccode_q;
      epc_d        = epc_q;
      badvaddr_d   = badvaddr_q;
      count_d      = TIMER_EN ? (count_q + 32'd1) : count_q;
      compare_d    = compare_q;
      timer_pend_d = timer_pend_q | (TIMER_EN && (count_q == compare_q));

      if (exc_take_s) begin
         exl_d     = 1'b1;
         bd_d      = bus.exc_bd;
         exccode_d = int_req_s ? 5'd0 : bus.exc_code;
         epc_d     = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
         if (!int_req_s && bad_addr_s) begin
            badvaddr_d = bus.exc_badvaddr;
         end else begin
            badvaddr_d = badvaddr_q;
         end
      end else if (bus.eret) begin
         exl_d = 1'b0;
      end else if (bus.cp0_we) begin
         case (bus.cp0_addr)
            5'd9: begin
               if (TIMER_EN) begin
                  count_d = bus.cp0_wdata;
               end else begin
                  count_d = count_q;
               end
            end
            5'd11: begin
               if (TIMER_EN) begin
                  compare_d    = bus.cp0_wdata;
                  timer_pend_d = 1'b0;
               end else begin
                  compare_d = compare_q;
               end
            end
            5'd12: begin
               im_d  = bus.cp0_wdata[15:10];
               exl_d = bus.cp0_wdata[1];
               ie_d  = bus.cp0_wdata[0];
            end
            5'd14:   epc_d = bus.cp0_wdata;
            default: epc_d = epc_q;
         endcase
      end else begin
         exl_d = exl_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         im_q         <= 6'd0;
         exl_q        <= 1'b0;
         ie_q         <= 1'b0;
         bd_q         <= 1'b0;
         ip_q         <= 6'd0;
         exccode_q    <= 5'd0;
         epc_q        <= 32'd0;
         badvaddr_q   <= 32'd0;
         count_q      <= 32'd0;
         compare_q    <= 32'hFFFF_FFFF;
         timer_pend_q <= 1'b0;
      end else begin
         im_q         <= im_d;
         exl_q        <= exl_d;
         ie_q         <= ie_d;
         bd_q         <= bd_d;
         ip_q         <= ip_d;
         exccode_q    <= exccode_d;
         epc_q        <= epc_d;
         badvaddr_q   <= badvaddr_d;
         count_q      <= count_d;
         compare_q    <= compare_d;
         timer_pend_q <= timer_pend_d;
      end
   end

   // mfc0 read mux on pre-edge register values
   always_comb begin
      case (bus.cp0_addr)
         5'd8:    bus.cp0_rdata = badvaddr_q;
         5'd9:    bus.cp0_rdata = TIMER_EN ? count_q : 32'd0;
         5'd11:   bus.cp0_rdata = TIMER_EN ? compare_q : 32'd0;
         5'd12:   bus.cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
         5'd13:   bus.cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
         5'd14:   bus.cp0_rdata = epc_q;
         5'd15:   bus.cp0_rdata = PRID_VALUE;
         default: bus.cp0_rdata = 32'd0;
      endcase
   end

   assign bus.exc_take   = exc_take_s;
   assign bus.handler_pc = EXC_VECTOR;
   assign bus.epc_out    = epc_q;
   assign bus.exl_out    = exl_q;

endmodule

// File: tb/tb_cp0_ctrl_v2.sv
// Directed bench for cp0_ctrl_v2: interrupt/exception entry, timer, eret,
// write-drop priority, nested exceptions and reset mid-handler.
module tb_cp0_ctrl_v2;

   logic Clk = 1'b0;
   logic Reset;
   int   n_run  = 0;
   int   n_fail = 0;
   int   k;

   cp0_ctrl_v2_if #(.NUM_HWINT(6)) bus ();

   cp0_ctrl_v2 #(
      .NUM_HWINT (6),
      .TIMER_EN  (1'b1),
      .PRID_VALUE(32'hCAFE_0001),
      .EXC_VECTOR(32'h0000_4180)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkreg(input string tag, input logic [4:0] a, input logic [31:0] exp);
      bus.cp0_addr = a;
      #1;
      chk(tag, bus.cp0_rdata, exp);
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.cp0_we    = 1'b1;
      bus.cp0_addr  = a;
      bus.cp0_wdata = d;
      tick();
      bus.cp0_we    = 1'b0;
   endtask

   task automatic do_eret;
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
   endtask

   initial begin
      Reset            = 1'b1;
      bus.hw_int       = 6'd0;
      bus.exc_req      = 1'b0;
      bus.exc_code     = 5'd0;
      bus.exc_bd       = 1'b0;
      bus.exc_pc       = 32'd0;
      bus.exc_badvaddr = 32'd0;
      bus.cp0_we       = 1'b0;
      bus.cp0_addr     = 5'd0;
      bus.cp0_wdata    = 32'd0;
      bus.eret         = 1'b0;
      tick();
      tick();

      // reset state
      chkreg("rst_sr", 5'd12, 32'h0000_0000);
      chkreg("rst_cause", 5'd13, 32'h0000_0000);
      chkreg("rst_compare", 5'd11, 32'hFFFF_FFFF);
      chkreg("rst_count", 5'd9, 32'h0000_0000);
      chk("rst_exl", {31'd0, bus.exl_out}, 32'd0);
      chk("handler_pc", bus.handler_pc, 32'h0000_4180);
      bus.exc_req = 1'b1;
      #1;
      chk("rst_take_gated", {31'd0, bus.exc_take}, 32'd0);
      bus.exc_req = 1'b0;
      Reset = 1'b0;

      // hardware interrupt 0 with IM0/IE enabled
      mtc0(5'd12, 32'h0000_0401);
      chkreg("sr_write", 5'd12, 32'h0000_0401);
      bus.hw_int = 6'b000001;
      bus.exc_pc = 32'h0000_1000;
      #1;
      chk("int_take", {31'd0, bus.exc_take}, 32'd1);
      tick();
      bus.hw_int = 6'd0;
      chkreg("int_cause", 5'd13, 32'h0000_0400);
      chk("int_exl", {31'd0, bus.exl_out}, 32'd1);
      chk("int_epc", bus.epc_out, 32'h0000_1000);
      chk("int_no_retake", {31'd0, bus.exc_take}, 32'd0);
      do_eret();
      chk("eret1_exl", {31'd0, bus.exl_out}, 32'd0);

      // AdEL in a delay slot
      bus.exc_req      = 1'b1;
      bus.exc_code     = 5'd4;
      bus.exc_bd       = 1'b1;
      bus.exc_pc       = 32'h0000_3010;
      bus.exc_badvaddr = 32'h7FFF_0001;
      #1;
      chk("adel_take", {31'd0, bus.exc_take}, 32'd1);
      tick();
      bus.exc_req = 1'b0;
      bus.exc_bd  = 1'b0;
      chkreg("adel_epc", 5'd14, 32'h0000_300C);
      chkreg("adel_cause", 5'd13, 32'h8000_0010);
      chkreg("adel_badv", 5'd8, 32'h7FFF_0001);
      do_eret();
      mtc0(5'd8, 32'h0000_5555);
      chkreg("badv_ro", 5'd8, 32'h7FFF_0001);
      chkreg("unmapped", 5'd3, 32'h0000_0000);
      chkreg("prid", 5'd15, 32'hCAFE_0001);

      // exception and interrupt together: interrupt wins
      bus.exc_req      = 1'b1;
      bus.exc_code     = 5'd5;
      bus.exc_pc       = 32'h0000_2000;
      bus.exc_badvaddr = 32'hDEAD_BEEF;
      bus.hw_int       = 6'b000001;
      #1;
      chk("both_take", {31'd0, bus.exc_take}, 32'd1);
      tick();
      bus.exc_req = 1'b0;
      bus.hw_int  = 6'd0;
      chkreg("both_cause", 5'd13, 32'h0000_0400);
      chkreg("both_badv", 5'd8, 32'h7FFF_0001);
      do_eret();
      chk("eret2_exl", {31'd0, bus.exl_out}, 32'd0);
      chk("eret2_epc", bus.epc_out, 32'h0000_2000);

      // timer: Compare=5, Count=0, IM7+IE
      bus.exc_pc = 32'h0000_4000;
      mtc0(5'd11, 32'h0000_0005);
      mtc0(5'd9, 32'h0000_0000);
      mtc0(5'd12, 32'h0000_8001);
      k = 0;
      #1;
      while (!bus.exc_take && k < 20) begin
         tick();
         k++;
      end
      chk("timer_latency", k, 32'd5);
      tick();
      chkreg("timer_cause", 5'd13, 32'h0000_8000);
      chk("timer_exl", {31'd0, bus.exl_out}, 32'd1);
      mtc0(5'd11, 32'hFFFF_FFFF);
      tick();
      chkreg("timer_ip7_clr", 5'd13, 32'h0000_0000);
      do_eret();
      chk("timer_no_take", {31'd0, bus.exc_take}, 32'd0);

      // exception coincident with mtc0 EPC: mtc0 dropped
      bus.exc_req   = 1'b1;
      bus.exc_code  = 5'd10;
      bus.exc_pc    = 32'h0000_5000;
      bus.cp0_we    = 1'b1;
      bus.cp0_addr  = 5'd14;
      bus.cp0_wdata = 32'h0000_1234;
      #1;
      chk("ri_take", {31'd0, bus.exc_take}, 32'd1);
      tick();
      bus.exc_req = 1'b0;
      bus.cp0_we  = 1'b0;
      chkreg("ri_epc", 5'd14, 32'h0000_5000);
      chkreg("ri_cause", 5'd13, 32'h0000_0028);

      // nested exception while EXL=1 is ignored
      bus.exc_req      = 1'b1;
      bus.exc_code     = 5'd4;
      bus.exc_pc       = 32'h0000_6000;
      bus.exc_badvaddr = 32'h0000_1111;
      #1;
      chk("nest_take", {31'd0, bus.exc_take}, 32'd0);
      tick();
      chkreg("nest_epc", 5'd14, 32'h0000_5000);
      chkreg("nest_badv", 5'd8, 32'h7FFF_0001);
      chkreg("nest_cause", 5'd13, 32'h0000_0028);

      // reset mid-handler with exc_req still high
      Reset = 1'b1;
      tick();
      chk("mid_rst_take", {31'd0, bus.exc_take}, 32'd0);
      chk("mid_rst_exl", {31'd0, bus.exl_out}, 32'd0);
      chkreg("mid_rst_sr", 5'd12, 32'h0000_0000);
      chkreg("mid_rst_compare", 5'd11, 32'hFFFF_FFFF);
      chkreg("mid_rst_epc", 5'd14, 32'h0000_0000);
      chkreg("mid_rst_cause", 5'd13, 32'h0000_0000);
      Reset       = 1'b0;
      bus.exc_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_ctrl_v2.md
Name: cp0_ctrl_v2

Overview:
Parametrised coprocessor-0 block for the pipelined MIPS core. It arbitrates exceptions and interrupts at the M stage and holds the SR, Cause, EPC, BadVAddr, PrID, Count and Compare registers. It adds a configurable number of hardware interrupt lines, a Count/Compare timer interrupt and a BadVAddr register. It drives the redirect signals the fetch stage uses for handler entry and ERET.

Parameters:
NUM_HWINT, 6, number of external interrupt lines (1..6), mapped to IP[2+i].
TIMER_EN, 1, 1 = Count/Compare timer present; timer pending ORs into IP7.
PRID_VALUE, 32'h0000_0000, constant returned by PrID.
EXC_VECTOR, 32'h0000_4180, handler entry address.

Ports:
Clk  in  1  clock
Reset  in  1  reset
hw_int  in  NUM_HWINT  level-sensitive external interrupt requests
exc_req  in  1  M-stage instruction has an exception
exc_code  in  5  ExcCode of the M-stage exception
exc_bd  in  1  M-stage instruction sits in a branch delay slot
exc_pc  in  32  PC of the M-stage instruction
exc_badvaddr  in  32  faulting address (AdEL/AdES)
cp0_we  in  1  mtc0 in M
cp0_addr  in  5  rd field of mtc0/mfc0
cp0_wdata  in  32  mtc0 data
eret  in  1  eret in M
cp0_rdata  out  32  mfc0 read data (combinational)
exc_take  out  1  handler entry this cycle (combinational)
handler_pc  out  32  EXC_VECTOR
epc_out  out  32  current EPC, used as the eret target
exl_out  out  1  SR.EXL

Behaviour:
- Clock is Clk. Reset is Reset: synchronous, active-high.
- Reset values:
  - SR = 0 (IM = 0, EXL = 0, IE = 0).
  - Cause = 0.
  - EPC, BadVAddr, Count = 0.
  - Compare = 32'hFFFF_FFFF.
  - timer_pend = 0.
  - Outputs follow from these registers.
- Register map:
  - 8 BadVAddr (read-only).
  - 9 Count.
  - 11 Compare.
  - 12 SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
  - 13 Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0} (read-only).
  - 14 EPC.
  - 15 PrID.
  - All other addresses read 0. Writes to read-only or unmapped addresses are ignored.
- Cause.IP is updated every cycle:
  - IP[2+i] = hw_int[i]; unused IP bits are 0.
  - IP7 additionally ORs timer_pend when TIMER_EN = 1.
- Interrupt condition: int_req = IE & ~EXL & |(IP_next & IM), where IP_next is the combinational value for this cycle.
- Exception condition: exc_ok = exc_req & ~EXL.
- exc_take = int_req | exc_ok. Interrupts have priority over exceptions.
- On exc_take, at the next edge:
  - EXL <= 1.
  - BD <= exc_bd.
  - ExcCode <= int_req ? 0 : exc_code.
  - EPC <= exc_bd ? exc_pc - 4 : exc_pc.
  - BadVAddr <= exc_badvaddr, only if the exception is not an interrupt and exc_code is 4 or 5.
- Priority within a cycle: exc_take > eret > cp0_we.
  - An mtc0 or eret coincident with exc_take is dropped.
  - eret clears EXL.
  - mtc0 writes the addressed register.
- Timer (TIMER_EN = 1):
  - Count increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count loads cp0_wdata that cycle, with no increment.
  - When Count == Compare (pre-increment value), timer_pend <= 1. It is sticky.
  - An mtc0 to Compare loads Compare and clears timer_pend in the same edge; the clear wins over a coincident match.
- Timer (TIMER_EN = 0): Count/Compare read 0 and timer_pend stays 0.
- A nested exception while EXL = 1 gives no take and no register change. Instructions are expected not to fault inside the handler.
- Reset asserted mid-handler: all registers return to reset values at that edge; exc_take is 0 during reset.
- cp0_rdata reflects pre-edge register values; there is no read-after-write bypass inside this block.

Test Plan:
1. Reset, then IM = 6'b000001 and IE = 1 via mtc0 SR = 32'h0000_0401, then hw_int[0] = 1 -> exc_take = 1 that cycle. Next cycle: Cause = 32'h0000_0400, EXL = 1, EPC = exc_pc.
2. exc_req with exc_code = 4, exc_bd = 1, exc_pc = 32'h3010, exc_badvaddr = 32'h7FFF_0001 -> EPC = 32'h300C, Cause = 32'h8000_0010, BadVAddr = 32'h7FFF_0001.
3. exc_req and an enabled interrupt in the same cycle -> ExcCode = 0. Then eret -> EXL = 0 and epc_out unchanged.
4. mtc0 Compare = 5, mtc0 Count = 0, IM7 and IE enabled -> exc_take about 5 cycles later with Cause.IP7 = 1. Then mtc0 Compare -> IP7 clears next cycle.
5. exc_take coincident with mtc0 EPC = 32'h1234 -> EPC holds the exception PC, not 32'h1234.
6. With EXL = 1, exc_req asserted -> no exc_take, registers unchanged. Reset mid-handler -> SR = 0, Compare = 32'hFFFF_FFFF.
